// File: rtl/desc_pkg.sv
// Shared types and field layout for the descriptor fetch engine.
// A descriptor is four 32-bit words; word3 carries the ownership and chain flags.
package desc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      CHECK,
      PRESENT,
      WRITEBACK
   } state_t;

   localparam int DESC_WORDS = 4;
   localparam int OWNED_BIT  = 31;
   localparam int LAST_BIT   = 30;
   localparam int LEN_MSB    = 23;

   localparam logic [3:0] WB_BYTEENABLE = 4'b1000;
   localparam logic [3:0] RD_BYTEENABLE = 4'b1111;

   // Hand the descriptor back to software: clear OWNED, keep every other bit.
   function automatic logic [31:0] writeback_word(input logic [31:0] word3);
      logic [31:0] w;
      w            = word3;
      w[OWNED_BIT] = 1'b0;
      return w;
   endfunction

endpackage

// File: rtl/descriptor_word_capture.sv
// Captures the four descriptor words returned by the memory one cycle after
// each read is issued, and presents them as one 128-bit beat.
module descriptor_word_capture
   import desc_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             rd_issue,
   input  logic [1:0]                       rd_word,
   input  logic                             flush,
   input  logic [DATA_WIDTH-1:0]            rdata,
   output logic [DESC_WORDS*DATA_WIDTH-1:0] desc_data
);

   logic [DATA_WIDTH-1:0] words [DESC_WORDS];
   logic                  pend_q;
   logic [1:0]            pend_idx_q;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: the capture array is only four flops and feeds desc_data, so it is reset unlike a real RAM.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q     <= 1'b0;
         pend_idx_q <= '0;
         for (int i = 0; i < DESC_WORDS; i++) words[i] <= '0;
      end else begin
         pend_q     <= rd_issue & ~flush;
         pend_idx_q <= rd_word;
         // An abort throws away a read result that is still on its way back.
         if (pend_q && !flush) words[pend_idx_q] <= rdata;
      end
   end

   assign desc_data = {words[3], words[2], words[1], words[0]};

endmodule

// File: rtl/descriptor_fetch_engine.sv
// Walks a ring of 4-word descriptors in the descriptor RAM, presents each owned
// descriptor as a 128-bit beat, then returns ownership to software.
module descriptor_fetch_engine
   import desc_pkg::*;
#(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_index,
   input  logic                  abort,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_WIDTH-1:0] mem_writedata,
   output logic [3:0]            mem_byteenable,
   output logic                  mem_clken,
   input  logic [DATA_WIDTH-1:0] mem_readdata,
   output logic                  desc_valid,
   input  logic                  desc_ready,
   output logic [127:0]          desc_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [15:0]           desc_count
);

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] cur_idx;
   logic [1:0]            fetch_cnt;
   logic                  rd_issue;
   logic                  misaligned;
   logic                  start_ok;
   logic [31:0]           word3;

   assign misaligned = (start_index[1:0] != 2'b00);
   assign start_ok   = start & ~abort & ~misaligned;
   assign word3      = desc_data[127:96];
   assign busy       = (state != IDLE);
   assign mem_clken  = 1'b1;

   descriptor_word_capture #(.DATA_WIDTH(DATA_WIDTH)) u_capture (
      .clk       (clk),
      .reset     (reset),
      .rd_issue  (rd_issue),
      .rd_word   (fetch_cnt),
      .flush     (abort),
      .rdata     (mem_readdata),
      .desc_data (desc_data)
   );

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_next     = state;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_writedata  = '0;
      mem_byteenable = '0;
      desc_valid     = 1'b0;
      done           = 1'b0;
      rd_issue       = 1'b0;
      case (state)
         IDLE: if (start_ok) state_next = FETCH;
         FETCH: begin
            rd_issue       = 1'b1;
            mem_chipselect = 1'b1;
            mem_byteenable = RD_BYTEENABLE;
            mem_address    = cur_idx + ADDR_WIDTH'(fetch_cnt);
            if (fetch_cnt == 2'd3) state_next = WAIT;
         end
         WAIT: state_next = CHECK;
         CHECK: begin
            if (word3[OWNED_BIT]) begin
               state_next = PRESENT;
            end else begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         PRESENT: begin
            desc_valid = 1'b1;
            if (desc_ready) state_next = WRITEBACK;
         end
         WRITEBACK: begin
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_address    = cur_idx + ADDR_WIDTH'(3);
            mem_byteenable = WB_BYTEENABLE;
            mem_writedata  = writeback_word(word3);
            if (word3[LAST_BIT]) begin
               done       = 1'b1;
               state_next = IDLE;
            end else begin
               state_next = FETCH;
            end
         end
         default: state_next = IDLE;
      endcase
      // Abort wins over everything outside IDLE: no access, no beat, no done.
      if (abort && state != IDLE) begin
         state_next     = IDLE;
         mem_chipselect = 1'b0;
         mem_write      = 1'b0;
         mem_address    = '0;
         mem_writedata  = '0;
         mem_byteenable = '0;
         desc_valid     = 1'b0;
         done           = 1'b0;
         rd_issue       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cur_idx    <= '0;
         fetch_cnt  <= '0;
         desc_count <= '0;
         error      <= 1'b0;
      end else begin
         state     <= state_next;
         error     <= (state == IDLE) & start & ~abort & misaligned;
         fetch_cnt <= (state == FETCH) ? fetch_cnt + 2'd1 : 2'd0;
         if (state == IDLE && start_ok) begin
            cur_idx    <= start_index;
            desc_count <= '0;
         end
         if (desc_valid && desc_ready && desc_count != 16'hFFFF)
            desc_count <= desc_count + 16'd1;
         // Ring advance wraps naturally at the address width.
         if (state == WRITEBACK && !abort && !word3[LAST_BIT])
            cur_idx <= cur_idx + ADDR_WIDTH'(DESC_WORDS);
      end
   end

endmodule

// File: tb/tb_descriptor_fetch_engine.sv
// Directed bench for descriptor_fetch_engine with a behavioural latency-1 RAM
// and a negedge monitor that logs every bus access and accepted beat.
module tb_descriptor_fetch_engine;

   localparam int AW = 11;

   logic          clk = 1'b0;
   logic          reset, start, abort, desc_ready;
   logic [AW-1:0] start_index;
   logic [AW-1:0] mem_address;
   logic          mem_chipselect, mem_write, mem_clken;
   logic [31:0]   mem_writedata, mem_readdata;
   logic [3:0]    mem_byteenable;
   logic          desc_valid, busy, done, error;
   logic [127:0]  desc_data;
   logic [15:0]   desc_count;

   logic [31:0]   tb_mem [0:2047];
   logic          bd_we;
   logic [AW-1:0] bd_addr;
   logic [31:0]   bd_data;

   int n_checks = 0;
   int n_fail   = 0;

   int            rd_total = 0, wr_total = 0, beat_total = 0;
   int            valid_total = 0, done_total = 0, error_total = 0;
   logic [AW-1:0] rd_log   [64];
   logic [127:0]  beat_log [64];
   logic [AW-1:0] last_wr_addr;
   logic [31:0]   last_wr_data;
   logic [3:0]    last_wr_be;

   always #5 clk = ~clk;

   descriptor_fetch_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .start_index    (start_index),
      .abort          (abort),
      .mem_address    (mem_address),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_byteenable (mem_byteenable),
      .mem_clken      (mem_clken),
      .mem_readdata   (mem_readdata),
      .desc_valid     (desc_valid),
      .desc_ready     (desc_ready),
      .desc_data      (desc_data),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .desc_count     (desc_count)
   );

   // Descriptor RAM: registered address, read data one cycle later, byte-enabled writes.
   always @(posedge clk) begin
      if (bd_we) begin
         tb_mem[bd_addr] <= bd_data;
      end else if (mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) tb_mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         end else begin
            mem_readdata <= tb_mem[mem_address];
         end
      end
   end

   always @(negedge clk) begin
      if (mem_chipselect && !mem_write) begin
         rd_log[rd_total % 64] <= mem_address;
         rd_total <= rd_total + 1;
      end
      if (mem_chipselect && mem_write) begin
         wr_total     <= wr_total + 1;
         last_wr_addr <= mem_address;
         last_wr_data <= mem_writedata;
         last_wr_be   <= mem_byteenable;
      end
      if (desc_valid && desc_ready) begin
         beat_log[beat_total % 64] <= desc_data;
         beat_total <= beat_total + 1;
      end
      if (desc_valid) valid_total <= valid_total + 1;
      if (done)       done_total  <= done_total + 1;
      if (error)      error_total <= error_total + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mem_put(input logic [AW-1:0] a, input logic [31:0] d);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      tick();
      bd_we = 1'b0;
   endtask

   task automatic load_desc(input int idx, input logic [31:0] w0, w1, w2, w3);
      mem_put(AW'(idx),     w0);
      mem_put(AW'(idx + 1), w1);
      mem_put(AW'(idx + 2), w2);
      mem_put(AW'(idx + 3), w3);
   endtask

   task automatic pulse_start(input logic [AW-1:0] idx);
      start_index = idx;
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0; desc_ready = 1'b0;
      start_index = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
      repeat (3) tick();
      n_checks++;
      if ({busy, done, error, desc_valid, mem_chipselect, mem_write} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {busy, done, error, desc_valid, mem_chipselect, mem_write});
      end
      n_checks++;
      if (mem_clken !== 1'b1) begin
         n_fail++; $display("FAIL reset_clken: got %b expected 1", mem_clken);
      end
      n_checks++;
      if (desc_count !== 16'd0 || desc_data !== 128'd0 || mem_address !== '0) begin
         n_fail++;
         $display("FAIL reset_regs: count %h data %h addr %h expected all zero",
                  desc_count, desc_data, mem_address);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_ring();
      logic [127:0] exp_beat [3];
      int  rd_base, wr_base, beat_base, done_base, bad;
      bit  ok;
      load_desc(0, 32'h1000_0000, 32'h2000_0000, 32'h0000_0040, 32'h8000_00A1);
      load_desc(4, 32'h1000_0100, 32'h2000_0100, 32'h0000_0080, 32'h8000_00B2);
      load_desc(8, 32'h1000_0200, 32'h2000_0200, 32'h0000_00C0, 32'hC000_00C3);
      exp_beat[0] = {32'h8000_00A1, 32'h0000_0040, 32'h2000_0000, 32'h1000_0000};
      exp_beat[1] = {32'h8000_00B2, 32'h0000_0080, 32'h2000_0100, 32'h1000_0100};
      exp_beat[2] = {32'hC000_00C3, 32'h0000_00C0, 32'h2000_0200, 32'h1000_0200};
      desc_ready = 1'b1;
      rd_base = rd_total; wr_base = wr_total; beat_base = beat_total; done_base = done_total;
      pulse_start('0);
      wait_idle(200, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL ring_timeout: busy %b expected 0", busy); end
      n_checks++;
      if (beat_total - beat_base !== 3) begin
         n_fail++; $display("FAIL ring_beats: got %0d expected 3", beat_total - beat_base);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (beat_log[(beat_base + i) % 64] !== exp_beat[i]) begin
            n_fail++;
            $display("FAIL ring_beat%0d: got %h expected %h", i,
                     beat_log[(beat_base + i) % 64], exp_beat[i]);
         end
      end
      bad = 0;
      for (int i = 0; i < 12; i++)
         if (rd_log[(rd_base + i) % 64] !== AW'(i)) bad++;
      n_checks++;
      if (bad != 0 || rd_total - rd_base != 12) begin
         n_fail++;
         $display("FAIL ring_reads: %0d reads, %0d wrong addresses, expected 12 reads 0..11",
                  rd_total - rd_base, bad);
      end
      n_checks++;
      if (tb_mem[3] !== 32'h0000_00A1 || tb_mem[7] !== 32'h0000_00B2 || tb_mem[11] !== 32'h4000_00C3) begin
         n_fail++;
         $display("FAIL ring_writeback: got %h %h %h expected 000000a1 000000b2 400000c3",
                  tb_mem[3], tb_mem[7], tb_mem[11]);
      end
      n_checks++;
      if (wr_total - wr_base != 3 || last_wr_be !== 4'b1000 || last_wr_addr !== AW'(11)) begin
         n_fail++;
         $display("FAIL ring_writes: count %0d be %b addr %0d expected 3 1000 11",
                  wr_total - wr_base, last_wr_be, last_wr_addr);
      end
      n_checks++;
      if (done_total - done_base != 1 || desc_count !== 16'd3) begin
         n_fail++;
         $display("FAIL ring_done: done %0d count %0d expected 1 3",
                  done_total - done_base, desc_count);
      end
   endtask

   task automatic test_misaligned();
      int rd_base, wr_base, err_base;
      rd_base = rd_total; wr_base = wr_total; err_base = error_total;
      pulse_start(AW'(6));
      n_checks++;
      if (error !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL misaligned_pulse: error %b busy %b expected 1 0", error, busy);
      end
      tick();
      n_checks++;
      if (error !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL misaligned_clear: error %b busy %b expected 0 0", error, busy);
      end
      tick();
      n_checks++;
      if (rd_total != rd_base || wr_total != wr_base || error_total - err_base != 1) begin
         n_fail++;
         $display("FAIL misaligned_access: reads %0d writes %0d errors %0d expected 0 0 1",
                  rd_total - rd_base, wr_total - wr_base, error_total - err_base);
      end
   endtask

   task automatic test_not_owned();
      int rd_base, wr_base, val_base, early;
      load_desc(0, 32'h1234_0000, 32'h5678_0000, 32'h0000_0010, 32'h4000_0000);
      rd_base = rd_total; wr_base = wr_total; val_base = valid_total;
      pulse_start('0);
      early = 0;
      for (int i = 0; i < 5; i++) begin
         if (done !== 1'b0) early++;
         tick();
      end
      n_checks++;
      if (early != 0 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL not_owned_done: early pulses %0d done at +6 %b expected 0 1", early, done);
      end
      tick();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL not_owned_idle: busy %b done %b expected 0 0", busy, done);
      end
      n_checks++;
      if (valid_total != val_base || wr_total != wr_base || rd_total - rd_base != 4
          || tb_mem[3] !== 32'h4000_0000) begin
         n_fail++;
         $display("FAIL not_owned_bus: valid %0d writes %0d reads %0d word3 %h expected 0 0 4 40000000",
                  valid_total - val_base, wr_total - wr_base, rd_total - rd_base, tb_mem[3]);
      end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] exp_rd [8];
      int rd_base, beat_base, done_base, bad;
      bit ok;
      load_desc(2044, 32'h3000_0000, 32'h4000_0000, 32'h0000_0010, 32'h8000_0020);
      load_desc(0,    32'h3100_0000, 32'h4100_0000, 32'h0000_0020, 32'hC000_0021);
      exp_rd = '{AW'(2044), AW'(2045), AW'(2046), AW'(2047), AW'(0), AW'(1), AW'(2), AW'(3)};
      desc_ready = 1'b1;
      rd_base = rd_total; beat_base = beat_total; done_base = done_total;
      pulse_start(AW'(2044));
      wait_idle(200, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL wrap_timeout: busy %b expected 0", busy); end
      bad = 0;
      for (int i = 0; i < 8; i++)
         if (rd_log[(rd_base + i) % 64] !== exp_rd[i]) bad++;
      n_checks++;
      if (bad != 0 || rd_total - rd_base != 8) begin
         n_fail++;
         $display("FAIL wrap_reads: %0d reads, %0d wrong, expected 2044..2047 then 0..3",
                  rd_total - rd_base, bad);
      end
      n_checks++;
      if (beat_total - beat_base != 2 || done_total - done_base != 1 || desc_count !== 16'd2) begin
         n_fail++;
         $display("FAIL wrap_beats: beats %0d done %0d count %0d expected 2 1 2",
                  beat_total - beat_base, done_total - done_base, desc_count);
      end
      n_checks++;
      if (beat_log[(beat_base + 1) % 64] !== {32'hC000_0021, 32'h0000_0020, 32'h4100_0000, 32'h3100_0000}) begin
         n_fail++;
         $display("FAIL wrap_beat1: got %h expected c00000210000002041000000310000 00",
                  beat_log[(beat_base + 1) % 64]);
      end
      n_checks++;
      if (tb_mem[2047] !== 32'h0000_0020 || tb_mem[3] !== 32'h4000_0021) begin
         n_fail++;
         $display("FAIL wrap_writeback: got %h %h expected 00000020 40000021", tb_mem[2047], tb_mem[3]);
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] exp_beat, held;
      int wr_base, beat_base, unstable, waited;
      bit ok;
      load_desc(0, 32'hAAAA_0000, 32'hBBBB_0000, 32'h0000_0100, 32'hC000_0010);
      exp_beat = {32'hC000_0010, 32'h0000_0100, 32'hBBBB_0000, 32'hAAAA_0000};
      desc_ready = 1'b0;
      wr_base = wr_total; beat_base = beat_total;
      pulse_start('0);
      waited = 0;
      while (desc_valid !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      n_checks++;
      if (desc_valid !== 1'b1 || desc_data !== exp_beat) begin
         n_fail++;
         $display("FAIL bp_present: valid %b data %h expected 1 %h", desc_valid, desc_data, exp_beat);
      end
      held = desc_data;
      unstable = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (desc_valid !== 1'b1 || desc_data !== held) unstable++;
      end
      n_checks++;
      if (unstable != 0 || wr_total != wr_base) begin
         n_fail++;
         $display("FAIL bp_hold: unstable cycles %0d writes %0d expected 0 0",
                  unstable, wr_total - wr_base);
      end
      desc_ready = 1'b1;
      tick();
      n_checks++;
      if (mem_write !== 1'b1 || mem_chipselect !== 1'b1 || mem_address !== AW'(3)
          || mem_byteenable !== 4'b1000 || mem_writedata !== 32'h4000_0010) begin
         n_fail++;
         $display("FAIL bp_writeback: we %b cs %b addr %0d be %b data %h expected 1 1 3 1000 40000010",
                  mem_write, mem_chipselect, mem_address, mem_byteenable, mem_writedata);
      end
      wait_idle(20, ok);
      n_checks++;
      if (!ok || wr_total - wr_base != 1 || beat_total - beat_base != 1 || desc_count !== 16'd1) begin
         n_fail++;
         $display("FAIL bp_totals: idle %b writes %0d beats %0d count %0d expected 1 1 1 1",
                  ok, wr_total - wr_base, beat_total - beat_base, desc_count);
      end
   endtask

   task automatic test_abort();
      int wr_base, val_base, done_base, beat_base;
      bit ok;
      load_desc(0, 32'h5000_0000, 32'h6000_0000, 32'h0000_0030, 32'hC000_0030);
      desc_ready = 1'b1;
      wr_base = wr_total; val_base = valid_total; done_base = done_total;
      pulse_start('0);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL abort_idle: busy %b expected 0", busy);
      end
      repeat (8) tick();
      n_checks++;
      if (busy !== 1'b0 || valid_total != val_base || wr_total != wr_base
          || done_total != done_base || tb_mem[3] !== 32'hC000_0030) begin
         n_fail++;
         $display("FAIL abort_quiet: busy %b valid %0d writes %0d done %0d word3 %h expected 0 0 0 0 c0000030",
                  busy, valid_total - val_base, wr_total - wr_base, done_total - done_base, tb_mem[3]);
      end
      start_index = '0;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL abort_beats_start: busy %b expected 0", busy);
      end
      beat_base = beat_total; done_base = done_total;
      pulse_start('0);
      wait_idle(100, ok);
      n_checks++;
      if (!ok || beat_total - beat_base != 1 || done_total - done_base != 1 || desc_count !== 16'd1
          || beat_log[beat_base % 64] !== {32'hC000_0030, 32'h0000_0030, 32'h6000_0000, 32'h5000_0000}) begin
         n_fail++;
         $display("FAIL abort_restart: idle %b beats %0d done %0d count %0d beat %h",
                  ok, beat_total - beat_base, done_total - done_base, desc_count, beat_log[beat_base % 64]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_ring();
      test_misaligned();
      test_not_owned();
      test_wrap();
      test_backpressure();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
